axi_master_burst: RTL and testbench
===================================

Name: axi_master_burst

Overview:
- Synthesizable burst initiator for the team's simplified AXI4-style bus: WR_ADDR/WR_DATA channels and RD_ADDR/RD_DATA channels, with no write-response channel.
- It is the master-side counterpart to the bus slave memory model.
- User logic issues write and read burst commands and streams write data in and read data out.
- Write and read paths are independent FSMs and may run concurrently. Each path has one burst outstanding.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- LEN_W, 8, burst length field; beats = LEN+1
- ID_W, 4, transaction ID width

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- wr_cmd_valid/wr_cmd_ready  in/out  1/1  write-command handshake
- wr_cmd_addr/wr_cmd_len/wr_cmd_id  in  ADDR_W/LEN_W/ID_W  write-command fields
- wr_usr_data/wr_usr_strb  in  DATA_W/DATA_W/8  user write beat
- wr_usr_valid/wr_usr_ready  in/out  1/1  user write-data handshake
- wr_done/wr_done_id  out  1/ID_W  one-cycle pulse when a write burst completes, with its ID
- rd_cmd_valid/rd_cmd_ready  in/out  1/1  read-command handshake
- rd_cmd_addr/rd_cmd_len/rd_cmd_id  in  ADDR_W/LEN_W/ID_W  read-command fields
- rd_usr_data/rd_usr_id/rd_usr_last  out  DATA_W/ID_W/1  user read beat
- rd_usr_valid/rd_usr_ready  out/in  1/1  user read-data handshake
- rd_done/rd_err  out  1/1  completion pulse; sticky protocol-error flag
- WR_ADDR/WR_LEN/WR_ID/WR_ADDR_VALID  out  ADDR_W/LEN_W/ID_W/1  bus write-address channel
- WR_ADDR_READY  in  1  bus write-address ready
- WR_DATA/WR_STRB/WR_DATA_VALID/WR_DATA_LAST  out  DATA_W/DATA_W/8/1/1  bus write-data channel
- WR_DATA_READY  in  1  bus write-data ready
- WR_BACK_ID  in  ID_W  write ID returned by the slave (ignored except in assertions)
- RD_ADDR/RD_LEN/RD_ID/RD_ADDR_VALID  out  ADDR_W/LEN_W/ID_W/1  bus read-address channel
- RD_ADDR_READY  in  1  bus read-address ready
- RD_DATA/RD_BACK_ID/RD_DATA_LAST/RD_DATA_VALID  in  DATA_W/ID_W/1/1  bus read-data channel
- RD_DATA_READY  out  1  bus read-data ready

Behaviour:
- Reset and clocking:
  - Single clock clk. Reset rstn is synchronous and active-low.
  - On reset all registered outputs are 0: bus VALIDs, LAST, addr/len/id/data/strb regs, wr_done, rd_done, rd_err.
  - Both FSMs go to IDLE; the hold register and beat counters clear.
  - Reset mid-burst aborts silently: no done pulse, bus VALIDs drop the next edge.
- Command acceptance:
  - wr_cmd_ready = (wstate==W_IDLE) && rstn; likewise rd_cmd_ready for the read path.
  - Fields are captured on the handshake.
- Write FSM (W_IDLE -> W_ADDR -> W_DATA -> W_DONE -> W_IDLE):
  - W_ADDR: WR_ADDR_VALID=1 from the cycle after command accept. It is held with stable fields until WR_ADDR_READY is sampled high, then moves to W_DATA.
  - W_DATA: a one-entry hold register drives WR_DATA/WR_STRB/WR_DATA_VALID.
  - wr_usr_ready = !hold_full || (WR_DATA_VALID && WR_DATA_READY), gated off once LEN+1 beats are loaded.
  - WR_DATA_VALID never drops before its handshake; the slave counts consecutive VALID cycles before asserting READY.
  - WR_DATA_LAST=1 exactly on the beat whose sent count == LEN.
  - After the LAST handshake the FSM enters W_DONE; wr_done=1 for one cycle with the captured ID.
  - WR_ADDR is the burst start address; the slave increments internally.
- Read FSM (R_IDLE -> R_ADDR -> R_DATA -> R_DONE -> R_IDLE):
  - R_ADDR: RD_ADDR_VALID is held until RD_ADDR_READY.
  - R_DATA: RD_DATA_READY = rd_usr_ready, combinational pass-through. rd_usr_valid = RD_DATA_VALID.
  - rd_usr_data/rd_usr_id pass through from the bus.
  - rd_usr_last = (beat count == LEN).
  - Burst end is counter-based: the handshake at count==LEN goes to R_DONE, with rd_done=1 for one cycle.
  - RD_DATA_READY=0 outside R_DATA.
- Error checking:
  - Per read beat, if RD_BACK_ID != captured ID or RD_DATA_LAST != (count==LEN), rd_err is set.
  - rd_err is sticky and cleared on the next read-command accept.
- Boundaries:
  - LEN=0 gives a single beat with LAST on the first beat.
  - LEN=255 gives 256 beats; the beat counter is LEN_W+1 bits wide to avoid wrap.
  - Commands presented while busy stall (ready=0) and are never dropped.
  - Simultaneous write and read activity is fully independent.

Decomposition:
- Package axi_bus_pkg holds:
  - ADDR_W, DATA_W, LEN_W, ID_W constants;
  - typedef enum wr_state_t {W_IDLE,W_ADDR,W_DATA,W_DONE};
  - typedef enum rd_state_t {R_IDLE,R_ADDR,R_DATA,R_DONE}.
- One sub-module, axi_beat_hold_reg: the one-entry valid/ready hold register for data+strb. It is reused by future initiators.

Test Plan:
- Write addr=0x10, len=3, id=5, data 0xA0..0xA3 into the slave model -> 4 WR_DATA handshakes, LAST on the 4th only, WR_ADDR=0x10, wr_done=1 one cycle with wr_done_id=5.
- Read addr=0x10, len=3, id=5 after that write -> rd_usr_data 0xA0,0xA1,0xA2,0xA3; rd_usr_last on the 4th; rd_done pulse; rd_err=0.
- len=0 write 0xDEADBEEF then read -> single beat, LAST high on first beat, read returns 0xDEADBEEF.
- Read len=7 with rd_usr_ready toggling 1,0,1,0 -> RD_DATA_READY mirrors it, 8 beats delivered in order, none duplicated or lost.
- Concurrent write (len=15) and read (len=15) issued the same cycle -> both complete, wr_done and rd_done each pulse once; a second wr_cmd during the write sees wr_cmd_ready=0 until W_IDLE.
- Faulty responder returns RD_BACK_ID=3 for id=5, or early RD_DATA_LAST -> rd_err=1 until next rd_cmd accept. Assert rstn=0 mid-write -> WR_DATA_VALID=0 next cycle, no wr_done.

Source files
------------

// File: rtl/axi_bus_pkg.sv
// axi_bus_pkg: shared widths and FSM state types for the
// simplified AXI4-style bus initiators.
package axi_bus_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;
  localparam int ID_W   = 4;

  typedef enum logic [1:0] {
    W_IDLE, W_ADDR, W_DATA, W_DONE
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE, R_ADDR, R_DATA, R_DONE
  } rd_state_t;
endpackage

// File: rtl/axi_beat_hold_reg.sv
// axi_beat_hold_reg: one-entry valid/ready hold register.
// Accepts a new beat in the same cycle the held one drains.
module axi_beat_hold_reg #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);
  logic [W-1:0] data_q;
  logic         full_q;

  assign in_ready_o  = !full_q || out_ready_i;
  assign out_valid_o = full_q;
  assign out_data_o  = data_q;

  // load on input handshake, empty on output handshake
  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      data_q <= in_data_i;
      full_q <= 1'b1;
    end else if (out_ready_i) begin
      full_q <= 1'b0;
    end
  end
endmodule

// File: rtl/axi_master_burst.sv
// axi_master_burst: burst initiator for the simplified AXI4-style bus.
// Independent write/read FSMs, one burst outstanding per path.
module axi_master_burst #(
  parameter int ADDR_W = axi_bus_pkg::ADDR_W,
  parameter int DATA_W = axi_bus_pkg::DATA_W,
  parameter int LEN_W  = axi_bus_pkg::LEN_W,
  parameter int ID_W   = axi_bus_pkg::ID_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_cmd_valid,
  output logic              wr_cmd_ready,
  input  logic [ADDR_W-1:0] wr_cmd_addr,
  input  logic [LEN_W-1:0]  wr_cmd_len,
  input  logic [ID_W-1:0]   wr_cmd_id,
  input  logic [DATA_W-1:0] wr_usr_data,
  input  logic [DATA_W/8-1:0] wr_usr_strb,
  input  logic              wr_usr_valid,
  output logic              wr_usr_ready,
  output logic              wr_done,
  output logic [ID_W-1:0]   wr_done_id,
  input  logic              rd_cmd_valid,
  output logic              rd_cmd_ready,
  input  logic [ADDR_W-1:0] rd_cmd_addr,
  input  logic [LEN_W-1:0]  rd_cmd_len,
  input  logic [ID_W-1:0]   rd_cmd_id,
  output logic [DATA_W-1:0] rd_usr_data,
  output logic [ID_W-1:0]   rd_usr_id,
  output logic              rd_usr_last,
  output logic              rd_usr_valid,
  input  logic              rd_usr_ready,
  output logic              rd_done,
  output logic              rd_err,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [LEN_W-1:0]  WR_LEN,
  output logic [ID_W-1:0]   WR_ID,
  output logic              WR_ADDR_VALID,
  input  logic              WR_ADDR_READY,
  output logic [DATA_W-1:0] WR_DATA,
  output logic [DATA_W/8-1:0] WR_STRB,
  output logic              WR_DATA_VALID,
  output logic              WR_DATA_LAST,
  input  logic              WR_DATA_READY,
  input  logic [ID_W-1:0]   WR_BACK_ID,
  output logic [ADDR_W-1:0] RD_ADDR,
  output logic [LEN_W-1:0]  RD_LEN,
  output logic [ID_W-1:0]   RD_ID,
  output logic              RD_ADDR_VALID,
  input  logic              RD_ADDR_READY,
  input  logic [DATA_W-1:0] RD_DATA,
  input  logic [ID_W-1:0]   RD_BACK_ID,
  input  logic              RD_DATA_LAST,
  input  logic              RD_DATA_VALID,
  output logic              RD_DATA_READY
);
  import axi_bus_pkg::*;

  localparam int SW = DATA_W / 8;
  localparam logic [LEN_W:0] ONE = 1;

  wr_state_t         ws_q, ws_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [LEN_W-1:0]  wlen_q, wlen_d;
  logic [ID_W-1:0]   wid_q, wid_d;
  logic [LEN_W:0]    wld_q, wld_d;
  logic [LEN_W:0]    wsnt_q, wsnt_d;

  rd_state_t         rs_q, rs_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [LEN_W-1:0]  rlen_q, rlen_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [LEN_W:0]    rcnt_q, rcnt_d;
  logic              rerr_q, rerr_d;

  logic w_more, h_in_valid, h_in_ready, w_hs;
  logic r_hs, r_last;

  // write path: user beats flow through the hold register to the bus
  assign w_more       = wld_q <= {1'b0, wlen_q};
  assign h_in_valid   = (ws_q == W_DATA) && w_more && wr_usr_valid;
  assign wr_usr_ready = (ws_q == W_DATA) && w_more && h_in_ready;
  assign w_hs         = WR_DATA_VALID && WR_DATA_READY;
  assign WR_DATA_LAST = WR_DATA_VALID && (wsnt_q == {1'b0, wlen_q});

  axi_beat_hold_reg #(.W(DATA_W + SW)) u_hold (
    .clk         (clk),
    .rstn        (rstn),
    .in_data_i   ({wr_usr_strb, wr_usr_data}),
    .in_valid_i  (h_in_valid),
    .in_ready_o  (h_in_ready),
    .out_data_o  ({WR_STRB, WR_DATA}),
    .out_valid_o (WR_DATA_VALID),
    .out_ready_i (WR_DATA_READY)
  );

  assign wr_cmd_ready  = (ws_q == W_IDLE) && rstn;
  assign WR_ADDR       = waddr_q;
  assign WR_LEN        = wlen_q;
  assign WR_ID         = wid_q;
  assign WR_ADDR_VALID = ws_q == W_ADDR;
  assign wr_done       = ws_q == W_DONE;
  assign wr_done_id    = wid_q;

  // write FSM next state and beat counters
  always_comb begin
    ws_d    = ws_q;
    waddr_d = waddr_q;
    wlen_d  = wlen_q;
    wid_d   = wid_q;
    wld_d   = wld_q;
    wsnt_d  = wsnt_q;
    unique case (ws_q)
      W_IDLE: if (wr_cmd_valid && wr_cmd_ready) begin
        waddr_d = wr_cmd_addr;
        wlen_d  = wr_cmd_len;
        wid_d   = wr_cmd_id;
        wld_d   = '0;
        wsnt_d  = '0;
        ws_d    = W_ADDR;
      end
      W_ADDR: if (WR_ADDR_READY) ws_d = W_DATA;
      W_DATA: begin
        if (wr_usr_valid && wr_usr_ready) wld_d = wld_q + ONE;
        if (w_hs) begin
          wsnt_d = wsnt_q + ONE;
          if (WR_DATA_LAST) ws_d = W_DONE;
        end
      end
      W_DONE: ws_d = W_IDLE;
      default: ws_d = W_IDLE;
    endcase
  end

  // write path state registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ws_q    <= W_IDLE;
      waddr_q <= '0;
      wlen_q  <= '0;
      wid_q   <= '0;
      wld_q   <= '0;
      wsnt_q  <= '0;
    end else begin
      ws_q    <= ws_d;
      waddr_q <= waddr_d;
      wlen_q  <= wlen_d;
      wid_q   <= wid_d;
      wld_q   <= wld_d;
      wsnt_q  <= wsnt_d;
    end
  end

  // read path: bus data passes straight through to the user
  assign r_last        = rcnt_q == {1'b0, rlen_q};
  assign RD_DATA_READY = (rs_q == R_DATA) && rd_usr_ready;
  assign rd_usr_valid  = (rs_q == R_DATA) && RD_DATA_VALID;
  assign rd_usr_data   = RD_DATA;
  assign rd_usr_id     = RD_BACK_ID;
  assign rd_usr_last   = (rs_q == R_DATA) && r_last;
  assign r_hs          = RD_DATA_VALID && RD_DATA_READY;

  assign rd_cmd_ready  = (rs_q == R_IDLE) && rstn;
  assign RD_ADDR       = raddr_q;
  assign RD_LEN        = rlen_q;
  assign RD_ID         = rid_q;
  assign RD_ADDR_VALID = rs_q == R_ADDR;
  assign rd_done       = rs_q == R_DONE;
  assign rd_err        = rerr_q;

  // read FSM next state, beat counter and protocol check
  always_comb begin
    rs_d    = rs_q;
    raddr_d = raddr_q;
    rlen_d  = rlen_q;
    rid_d   = rid_q;
    rcnt_d  = rcnt_q;
    rerr_d  = rerr_q;
    unique case (rs_q)
      R_IDLE: if (rd_cmd_valid && rd_cmd_ready) begin
        raddr_d = rd_cmd_addr;
        rlen_d  = rd_cmd_len;
        rid_d   = rd_cmd_id;
        rcnt_d  = '0;
        rerr_d  = 1'b0;
        rs_d    = R_ADDR;
      end
      R_ADDR: if (RD_ADDR_READY) rs_d = R_DATA;
      R_DATA: if (r_hs) begin
        if (RD_BACK_ID != rid_q || RD_DATA_LAST != r_last)
          rerr_d = 1'b1;
        rcnt_d = rcnt_q + ONE;
        if (r_last) rs_d = R_DONE;
      end
      R_DONE: rs_d = R_IDLE;
      default: rs_d = R_IDLE;
    endcase
  end

  // read path state registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rs_q    <= R_IDLE;
      raddr_q <= '0;
      rlen_q  <= '0;
      rid_q   <= '0;
      rcnt_q  <= '0;
      rerr_q  <= 1'b0;
    end else begin
      rs_q    <= rs_d;
      raddr_q <= raddr_d;
      rlen_q  <= rlen_d;
      rid_q   <= rid_d;
      rcnt_q  <= rcnt_d;
      rerr_q  <= rerr_d;
    end
  end

  a_wr_back_id: assert property (@(posedge clk) disable iff (!rstn)
    w_hs |-> WR_BACK_ID == wid_q);
endmodule

// File: tb/tb_axi_master_burst.sv
// tb_axi_master_burst: random/directed bursts against a slave model,
// scoreboard queues checked by negedge monitors.
`timescale 1ns/1ps
module tb_axi_master_burst;
  logic clk = 0;
  logic rstn = 0;
  always #5 clk = ~clk;

  logic        wr_cmd_valid, wr_cmd_ready;
  logic [31:0] wr_cmd_addr;
  logic [7:0]  wr_cmd_len;
  logic [3:0]  wr_cmd_id;
  logic [31:0] wr_usr_data;
  logic [3:0]  wr_usr_strb;
  logic        wr_usr_valid, wr_usr_ready;
  logic        wr_done;
  logic [3:0]  wr_done_id;
  logic        rd_cmd_valid, rd_cmd_ready;
  logic [31:0] rd_cmd_addr;
  logic [7:0]  rd_cmd_len;
  logic [3:0]  rd_cmd_id;
  logic [31:0] rd_usr_data;
  logic [3:0]  rd_usr_id;
  logic        rd_usr_last, rd_usr_valid, rd_usr_ready;
  logic        rd_done, rd_err;
  logic [31:0] WR_ADDR;
  logic [7:0]  WR_LEN;
  logic [3:0]  WR_ID;
  logic        WR_ADDR_VALID, WR_ADDR_READY;
  logic [31:0] WR_DATA;
  logic [3:0]  WR_STRB;
  logic        WR_DATA_VALID, WR_DATA_LAST, WR_DATA_READY;
  logic [3:0]  WR_BACK_ID;
  logic [31:0] RD_ADDR;
  logic [7:0]  RD_LEN;
  logic [3:0]  RD_ID;
  logic        RD_ADDR_VALID, RD_ADDR_READY;
  logic [31:0] RD_DATA;
  logic [3:0]  RD_BACK_ID;
  logic        RD_DATA_LAST, RD_DATA_VALID, RD_DATA_READY;

  axi_master_burst dut (
    .clk(clk), .rstn(rstn),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
    .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len),
    .wr_cmd_id(wr_cmd_id),
    .wr_usr_data(wr_usr_data), .wr_usr_strb(wr_usr_strb),
    .wr_usr_valid(wr_usr_valid), .wr_usr_ready(wr_usr_ready),
    .wr_done(wr_done), .wr_done_id(wr_done_id),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len),
    .rd_cmd_id(rd_cmd_id),
    .rd_usr_data(rd_usr_data), .rd_usr_id(rd_usr_id),
    .rd_usr_last(rd_usr_last), .rd_usr_valid(rd_usr_valid),
    .rd_usr_ready(rd_usr_ready),
    .rd_done(rd_done), .rd_err(rd_err),
    .WR_ADDR(WR_ADDR), .WR_LEN(WR_LEN), .WR_ID(WR_ID),
    .WR_ADDR_VALID(WR_ADDR_VALID), .WR_ADDR_READY(WR_ADDR_READY),
    .WR_DATA(WR_DATA), .WR_STRB(WR_STRB),
    .WR_DATA_VALID(WR_DATA_VALID), .WR_DATA_LAST(WR_DATA_LAST),
    .WR_DATA_READY(WR_DATA_READY), .WR_BACK_ID(WR_BACK_ID),
    .RD_ADDR(RD_ADDR), .RD_LEN(RD_LEN), .RD_ID(RD_ID),
    .RD_ADDR_VALID(RD_ADDR_VALID), .RD_ADDR_READY(RD_ADDR_READY),
    .RD_DATA(RD_DATA), .RD_BACK_ID(RD_BACK_ID),
    .RD_DATA_LAST(RD_DATA_LAST), .RD_DATA_VALID(RD_DATA_VALID),
    .RD_DATA_READY(RD_DATA_READY)
  );

  assign WR_BACK_ID = WR_ID;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string nm,
                                input logic [63:0] act,
                                input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic void unexpected(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event want none queued", nm);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) o[8*b +: 8] = d[8*b +: 8];
    return o;
  endfunction

  typedef struct packed {
    logic [31:0] d; logic [3:0] s; logic l;
  } wbeat_t;
  typedef struct packed {
    logic [31:0] d; logic [3:0] id; logic l;
  } rbeat_t;
  typedef struct packed {
    logic [31:0] a; logic [7:0] len; logic [3:0] id; logic [1:0] f;
  } rburst_t;

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];
  wbeat_t      wexp_q[$];
  logic [43:0] awexp_q[$];
  logic [3:0]  wdone_q[$];
  logic [31:0] usr_d_q[$];
  logic [3:0]  usr_s_q[$];
  rbeat_t      rexp_q[$];
  logic [43:0] arexp_q[$];
  logic        rdone_q[$];
  logic [1:0]  rfault_q[$];
  logic [31:0] fixed_q[$];
  int          rmode = 0;

  // ---------------- slave model ----------------
  logic        aw_h, w_h, ar_h, r_h, s_rst;
  logic [31:0] s_waddr, s_wdata, s_raddr, sw_base, s_k;
  logic [3:0]  s_wstrb, s_rid;
  logic [7:0]  s_rlen;
  int          sw_i, sb_i;
  rburst_t     sb_q[$];
  rburst_t     rb;

  initial begin
    WR_ADDR_READY = 0; WR_DATA_READY = 0; RD_ADDR_READY = 0;
    RD_DATA_VALID = 0; RD_DATA = 0; RD_BACK_ID = 0; RD_DATA_LAST = 0;
    sw_base = 0; sw_i = 0; sb_i = 0;
    forever begin
      @(negedge clk);
      s_rst = !rstn;
      aw_h = rstn && WR_ADDR_VALID && WR_ADDR_READY;
      w_h  = rstn && WR_DATA_VALID && WR_DATA_READY;
      ar_h = rstn && RD_ADDR_VALID && RD_ADDR_READY;
      r_h  = rstn && RD_DATA_VALID && RD_DATA_READY;
      s_waddr = WR_ADDR; s_wdata = WR_DATA; s_wstrb = WR_STRB;
      s_raddr = RD_ADDR; s_rlen = RD_LEN; s_rid = RD_ID;
      @(posedge clk); #1;
      if (s_rst) begin
        sw_i = 0; sb_i = 0; sb_q.delete();
        RD_DATA_VALID = 0; RD_DATA_LAST = 0;
      end else begin
        if (aw_h) begin sw_base = s_waddr; sw_i = 0; end
        if (w_h) begin
          s_k = sw_base + 32'(sw_i * 4);
          slv_mem[s_k] = merge(slv_mem.exists(s_k) ? slv_mem[s_k] : 32'h0,
                               s_wdata, s_wstrb);
          sw_i++;
        end
        if (ar_h) begin
          rb.a = s_raddr; rb.len = s_rlen; rb.id = s_rid;
          rb.f = (rfault_q.size() > 0) ? rfault_q.pop_front() : 2'b00;
          sb_q.push_back(rb);
        end
        if (r_h) begin
          sb_i++;
          if (sb_i > int'(sb_q[0].len)) begin
            void'(sb_q.pop_front());
            sb_i = 0;
          end
          RD_DATA_VALID = 0;
        end
        if (!RD_DATA_VALID && sb_q.size() > 0 &&
            $urandom_range(0, 3) != 0) begin
          rb = sb_q[0];
          s_k = rb.a + 32'(sb_i * 4);
          RD_DATA = slv_mem.exists(s_k) ? slv_mem[s_k] : 32'h0;
          RD_BACK_ID = rb.f[0] ? 4'd3 : rb.id;
          RD_DATA_LAST = rb.f[1] ? (sb_i + 1 == int'(rb.len))
                                 : (sb_i == int'(rb.len));
          RD_DATA_VALID = 1;
        end
      end
      WR_ADDR_READY = 1'($urandom_range(0, 1));
      WR_DATA_READY = 1'($urandom_range(0, 1));
      RD_ADDR_READY = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- user-side drivers ----------------
  logic u_hs;
  initial begin
    wr_usr_valid = 0; wr_usr_data = 0; wr_usr_strb = 0;
    forever begin
      @(negedge clk);
      u_hs = rstn && wr_usr_valid && wr_usr_ready;
      @(posedge clk); #1;
      if (u_hs) begin
        void'(usr_d_q.pop_front());
        void'(usr_s_q.pop_front());
      end
      wr_usr_valid = usr_d_q.size() > 0 && $urandom_range(0, 3) != 0;
      if (usr_d_q.size() > 0) begin
        wr_usr_data = usr_d_q[0];
        wr_usr_strb = usr_s_q[0];
      end
    end
  end

  initial begin
    rd_usr_ready = 0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        1: rd_usr_ready = !rd_usr_ready;
        2: rd_usr_ready = 1;
        default: rd_usr_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitors ----------------
  logic        pw_v, pw_r;
  logic [35:0] pw_d;
  initial begin pw_v = 0; pw_r = 0; pw_d = 0; end

  always @(negedge clk) begin
    if (rstn) begin
      if (WR_ADDR_VALID && WR_ADDR_READY) begin
        if (awexp_q.size() == 0) unexpected("wr_addr_hs");
        else check("wr_addr", {WR_ADDR, WR_LEN, WR_ID}, awexp_q.pop_front());
      end
      if (pw_v && !pw_r)
        check("wdata_hold", {WR_DATA_VALID, WR_DATA, WR_STRB}, {1'b1, pw_d});
      if (WR_DATA_VALID && WR_DATA_READY) begin
        if (wexp_q.size() == 0) unexpected("wr_data_hs");
        else check("wr_beat", {WR_DATA, WR_STRB, WR_DATA_LAST},
                   wexp_q.pop_front());
      end
      if (wr_done) begin
        if (wdone_q.size() == 0) unexpected("wr_done");
        else check("wr_done_id", wr_done_id, wdone_q.pop_front());
      end
      if (RD_ADDR_VALID && RD_ADDR_READY) begin
        if (arexp_q.size() == 0) unexpected("rd_addr_hs");
        else check("rd_addr", {RD_ADDR, RD_LEN, RD_ID}, arexp_q.pop_front());
      end
      if (rd_usr_valid)
        check("rd_ready_mirror", RD_DATA_READY, rd_usr_ready);
      if (rd_usr_valid && rd_usr_ready) begin
        if (rexp_q.size() == 0) unexpected("rd_beat_hs");
        else check("rd_beat", {rd_usr_data, rd_usr_id, rd_usr_last},
                   rexp_q.pop_front());
      end
      if (rd_done) begin
        if (rdone_q.size() == 0) unexpected("rd_done");
        else check("rd_err_at_done", rd_err, rdone_q.pop_front());
      end
      pw_v = WR_DATA_VALID;
      pw_r = WR_DATA_READY;
      pw_d = {WR_DATA, WR_STRB};
    end else begin
      pw_v = 0;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic write_cmd(input logic [31:0] a, input logic [7:0] len,
                           input logic [3:0] id, input bit fixed,
                           input bit stall);
    logic [31:0] d, k;
    logic [3:0]  s;
    wbeat_t      wb;
    int          n;
    bit          got;
    for (int i = 0; i <= int'(len); i++) begin
      d = (fixed && fixed_q.size() > 0) ? fixed_q.pop_front() : $urandom;
      s = fixed ? 4'hF : 4'($urandom_range(1, 15));
      usr_d_q.push_back(d);
      usr_s_q.push_back(s);
      wb.d = d; wb.s = s; wb.l = (i == int'(len));
      wexp_q.push_back(wb);
      k = a + 32'(i * 4);
      ref_mem[k] = merge(ref_mem.exists(k) ? ref_mem[k] : 32'h0, d, s);
    end
    awexp_q.push_back({a, len, id});
    wdone_q.push_back(id);
    wr_cmd_addr = a; wr_cmd_len = len; wr_cmd_id = id;
    wr_cmd_valid = 1;
    n = 0; got = 0;
    while (!got && n < 4000) begin
      @(negedge clk);
      if (stall && n == 0) check("wr_cmd_stall", wr_cmd_ready, 1'b0);
      got = wr_cmd_ready;
      n++;
      @(posedge clk); #1;
    end
    wr_cmd_valid = 0;
    if (!got) check("wr_cmd_timeout", 0, 1);
  endtask

  task automatic read_cmd(input logic [31:0] a, input logic [7:0] len,
                          input logic [3:0] id, input logic [1:0] f);
    logic [31:0] k;
    rbeat_t      rbx;
    int          n;
    bit          got;
    for (int i = 0; i <= int'(len); i++) begin
      k = a + 32'(i * 4);
      rbx.d  = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
      rbx.id = f[0] ? 4'd3 : id;
      rbx.l  = (i == int'(len));
      rexp_q.push_back(rbx);
    end
    rfault_q.push_back(f);
    arexp_q.push_back({a, len, id});
    rdone_q.push_back(f != 2'b00);
    rd_cmd_addr = a; rd_cmd_len = len; rd_cmd_id = id;
    rd_cmd_valid = 1;
    n = 0; got = 0;
    while (!got && n < 4000) begin
      @(negedge clk);
      got = rd_cmd_ready;
      n++;
      @(posedge clk); #1;
    end
    rd_cmd_valid = 0;
    if (!got) check("rd_cmd_timeout", 0, 1);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((wexp_q.size() + awexp_q.size() + wdone_q.size() +
            rexp_q.size() + arexp_q.size() + rdone_q.size()) != 0 &&
           n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_drain"}, n < 20000, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  int n_done;
  int nw;

  initial begin
    wr_cmd_valid = 0; wr_cmd_addr = 0; wr_cmd_len = 0; wr_cmd_id = 0;
    rd_cmd_valid = 0; rd_cmd_addr = 0; rd_cmd_len = 0; rd_cmd_id = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs",
      {WR_ADDR_VALID, WR_DATA_VALID, WR_DATA_LAST, RD_ADDR_VALID,
       RD_DATA_READY, wr_done, rd_done, rd_err, wr_cmd_ready,
       rd_cmd_ready}, 10'h0);
    check("rst_regs", {WR_ADDR, WR_LEN, WR_ID, WR_DATA, WR_STRB}, 0);
    @(posedge clk); #2 rstn = 1;
    @(negedge clk);
    check("cmd_ready_idle", {wr_cmd_ready, rd_cmd_ready}, 2'b11);
    @(posedge clk); #1;

    // directed write then read-back
    fixed_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    write_cmd(32'h10, 8'd3, 4'd5, 1, 0);
    drain("wr_basic");
    read_cmd(32'h10, 8'd3, 4'd5, 2'b00);
    drain("rd_basic");

    // single-beat burst
    fixed_q = '{32'hDEADBEEF};
    write_cmd(32'h80, 8'd0, 4'd1, 1, 0);
    drain("wr_len0");
    read_cmd(32'h80, 8'd0, 4'd1, 2'b00);
    drain("rd_len0");

    // toggling user read ready
    rmode = 1;
    read_cmd(32'h10, 8'd7, 4'd6, 2'b00);
    drain("rd_toggle");
    rmode = 0;

    // concurrent write and read, plus a stalled second write
    write_cmd(32'h100, 8'd15, 4'd7, 0, 0);
    drain("wr_pre");
    fork
      begin
        write_cmd(32'h200, 8'd15, 4'd8, 0, 0);
        write_cmd(32'h300, 8'd3, 4'd9, 0, 1);
      end
      read_cmd(32'h100, 8'd15, 4'd10, 2'b00);
    join
    drain("concurrent");

    // longest burst
    write_cmd(32'h1000, 8'd255, 4'd11, 0, 0);
    drain("wr_len255");
    read_cmd(32'h1000, 8'd255, 4'd11, 2'b00);
    drain("rd_len255");

    // faulty responder: wrong ID, then early LAST
    read_cmd(32'h10, 8'd3, 4'd5, 2'b01);
    drain("rd_badid");
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rd_err_sticky", rd_err, 1'b1);
    @(posedge clk); #1;
    read_cmd(32'h10, 8'd3, 4'd5, 2'b00);
    check("rd_err_clear", rd_err, 1'b0);
    drain("rd_clean");
    read_cmd(32'h10, 8'd3, 4'd5, 2'b10);
    drain("rd_earlylast");
    read_cmd(32'h10, 8'd0, 4'd5, 2'b00);
    drain("rd_after_fault");

    // randomized traffic
    for (int it = 0; it < 15; it++) begin
      write_cmd(32'h2000 + 32'($urandom_range(0, 63) * 4),
                8'($urandom_range(0, 15)), 4'($urandom), 0, 0);
      drain("rnd_wr");
      read_cmd(32'h2000 + 32'($urandom_range(0, 63) * 4),
               8'($urandom_range(0, 15)), 4'($urandom), 2'b00);
      drain("rnd_rd");
    end

    // reset in the middle of a write burst
    write_cmd(32'h4000, 8'd15, 4'd2, 0, 0);
    nw = 0;
    while (!WR_DATA_VALID && nw < 2000) begin @(negedge clk); nw++; end
    check("rst_wait", nw < 2000, 1'b1);
    @(posedge clk); #2 rstn = 0;
    wexp_q.delete(); awexp_q.delete(); wdone_q.delete();
    usr_d_q.delete(); usr_s_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_outs",
      {WR_DATA_VALID, WR_ADDR_VALID, wr_done, wr_cmd_ready}, 4'h0);
    @(posedge clk); #2 rstn = 1;
    n_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (wr_done) n_done++;
    end
    check("rst_no_done", n_done, 0);
    @(posedge clk); #1;
    fixed_q = '{32'h12345678};
    write_cmd(32'h4000, 8'd0, 4'd3, 1, 0);
    drain("wr_post_rst");
    read_cmd(32'h4000, 8'd0, 4'd3, 2'b00);
    drain("rd_post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
